// File: rtl/mp_pkg.sv
// mp_pkg -- shared definitions for the multi-precision add/subtract block.
//   mp_state_e     : sequencer states (IDLE, RUN, DONE)
//   MP_WIDTH_DEF   : default operand width
//   MP_CHUNK_W_DEF : default adder slice width
//   mp_clog2()     : ceil(log2(v)), never less than 1, for counter sizing
package mp_pkg;

    localparam int MP_WIDTH_DEF   = 512;
    localparam int MP_CHUNK_W_DEF = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mp_state_e;

    // A one-slice configuration still needs a 1-bit index register.
    function automatic int mp_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mp_chunk_adder.sv
// mp_chunk_adder -- combinational CHUNK_W-bit adder slice.
//   a_i, b_i : slice operands (b_i arrives already inverted for subtraction)
//   cin_i    : carry into bit 0
//   sum_o    : CHUNK_W-bit sum
//   cout_o   : carry out of the slice MSB
module mp_chunk_adder #(
    parameter int CHUNK_W = 128
) (
    input  logic [CHUNK_W-1:0] a_i,
    input  logic [CHUNK_W-1:0] b_i,
    input  logic               cin_i,
    output logic [CHUNK_W-1:0] sum_o,
    output logic               cout_o
);

    logic [CHUNK_W:0] wide;

    assign wide   = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK_W{1'b0}}, cin_i};
    assign sum_o  = wide[CHUNK_W-1:0];
    assign cout_o = wide[CHUNK_W];

endmodule

// File: rtl/mp_addsub.sv
// mp_addsub -- sequential multi-precision adder/subtractor, one CHUNK_W
// slice per cycle, LSB slice first.
//   clk, resetn : clock (rising edge), synchronous active-low reset
//   start       : request, sampled only while idle
//   subtract    : 0 = A+B, 1 = A-B (computed as A + ~B + 1)
//   cond_sub    : conditional-subtract request
//   op_a, op_b  : operands, latched on an accepted start
//   busy        : high from the cycle after acceptance through the done cycle
//   done        : one-cycle pulse, result/carry_out valid
//   result      : sum/difference, held until the next accepted start
//   carry_out   : add = carry out; subtract = 1 when no borrow (A >= B)
// Build option: MP_ADDSUB_CONDSUB_EN enables conditional subtraction for
// Montgomery final reduction (keep op_a when the trial subtraction borrows).
module mp_addsub
    import mp_pkg::*;
#(
    parameter int WIDTH   = MP_WIDTH_DEF,
    parameter int CHUNK_W = MP_CHUNK_W_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             subtract,
    input  logic             cond_sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    localparam int N_CHUNKS = WIDTH / CHUNK_W;
    localparam int CNT_W    = mp_clog2(N_CHUNKS);
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(N_CHUNKS - 1);

    if ((CHUNK_W < 1) || (WIDTH < CHUNK_W) || ((WIDTH % CHUNK_W) != 0)) begin : g_bad_cfg
        $error("mp_addsub: WIDTH must be a non-zero multiple of CHUNK_W");
    end

    mp_state_e        state_q, state_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic             cin_q, cin_d;
    logic             sub_q, sub_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;

    logic [CHUNK_W-1:0] a_slice, b_slice, sum_slice;
    logic               slice_cout;
    logic               sel_a;

    assign a_slice = a_q[k_q*CHUNK_W +: CHUNK_W];
    // Inverting B here plus cin=1 on slice 0 gives two's-complement subtract.
    assign b_slice = sub_q ? ~b_q[k_q*CHUNK_W +: CHUNK_W] : b_q[k_q*CHUNK_W +: CHUNK_W];

    mp_chunk_adder #(.CHUNK_W(CHUNK_W)) u_chunk (
        .a_i    (a_slice),
        .b_i    (b_slice),
        .cin_i  (cin_q),
        .sum_o  (sum_slice),
        .cout_o (slice_cout)
    );

`ifdef MP_ADDSUB_CONDSUB_EN
    logic cond_q, cond_d;
    // Final borrow (no carry) on a conditional subtract restores A.
    assign sel_a = (state_q == ST_DONE) && cond_q && sub_q && !cout_q;
`else
    logic unused_cond_sub;
    assign unused_cond_sub = cond_sub;
    assign sel_a           = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        cin_d    = cin_q;
        sub_d    = sub_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;
`ifdef MP_ADDSUB_CONDSUB_EN
        cond_d   = cond_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = op_a;
                    b_d     = op_b;
                    sub_d   = subtract;
                    k_d     = '0;
                    cin_d   = subtract;
`ifdef MP_ADDSUB_CONDSUB_EN
                    cond_d  = cond_sub;
`endif
                end
            end
            ST_RUN: begin
                result_d[k_q*CHUNK_W +: CHUNK_W] = sum_slice;
                cin_d = slice_cout;
                k_d   = k_q + 1'b1;
                if (k_q == LAST_K) begin
                    state_d = ST_DONE;
                    cout_d  = slice_cout;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                // Make the restored A the held value once DONE is left.
                if (sel_a) result_d = a_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            cin_q    <= 1'b0;
            sub_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
`ifdef MP_ADDSUB_CONDSUB_EN
            cond_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            cin_q    <= cin_d;
            sub_q    <= sub_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
`ifdef MP_ADDSUB_CONDSUB_EN
            cond_q   <= cond_d;
`endif
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    // During DONE the selection is visible immediately; afterwards result_q holds it.
    assign result    = sel_a ? a_q : result_q;
    assign carry_out = cout_q;

endmodule
